// File: rtl/cp0_unit.sv
// cp0_unit: MIPS CP0 register file with prescaled Count/Compare timer, precise exception entry, ERET and interrupt qualification
// Ports: clk, rst (async, active-low); mtc0 write (we_i, waddr_i, data_i); mfc0 read (raddr_i -> data_o, combinational);
//        exception/ERET events (exc_valid_i, exc_code_i, eret_i, current_inst_addr_i, is_in_delayslot_i, badvaddr_i);
//        int_i hardware interrupt lines; register contents (count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o);
//        timer_int_o (Cause.TI) and int_req_o (qualified interrupt request).
// Optional: define CP0_BADVADDR_EN to build BadVAddr storage; otherwise badvaddr_o and reads of register 8 are 0.
module cp0_unit #(
  parameter int NUM_HW_INT = 6,
  parameter int COUNT_DIV = 1,
  parameter logic [31:0] PRID_VALUE = 32'h004C0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [4:0]            raddr_i,
  input  logic [31:0]           data_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic                  eret_i,
  input  logic [31:0]           current_inst_addr_i,
  input  logic                  is_in_delayslot_i,
  input  logic [31:0]           badvaddr_i,
  input  logic [NUM_HW_INT-1:0] int_i,
  output logic [31:0]           data_o,
  output logic [31:0]           count_o,
  output logic [31:0]           compare_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic [31:0]           badvaddr_o,
  output logic                  timer_int_o,
  output logic                  int_req_o
);
  localparam logic [31:0] STATUS_MASK = 32'h1000_FF03;
  localparam logic [3:0] PRE_LAST = 4'(COUNT_DIV - 1);
  logic [3:0] pre;
  logic armed, ti, bd, iv, wp;
  logic [1:0] sw_ip;
  logic [4:0] code;
  logic [NUM_HW_INT-1:0] hw_ip;
  logic [5:0] hw6;
  logic [31:0] status_n;
  logic tick, enter, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  assign tick = pre == PRE_LAST;
  // EPC/BD are only captured when not already inside an exception handler
  assign enter = exc_valid_i & ~status_o[1];
  assign wr_count = we_i && waddr_i == 5'd9;
  assign wr_compare = we_i && waddr_i == 5'd11;
  assign wr_status = we_i && waddr_i == 5'd12;
  assign wr_cause = we_i && waddr_i == 5'd13;
  assign wr_epc = we_i && waddr_i == 5'd14;
  assign hw6 = 6'(hw_ip);
  // IP7 shares its bit with the timer interrupt
  assign cause_o = {bd, ti, 6'b0, iv, wp, 6'b0, hw6[5] | ti, hw6[4:0], sw_ip, 1'b0, code, 2'b0};
  assign timer_int_o = ti;
  assign int_req_o = status_o[0] & ~status_o[1] & |(cause_o[15:8] & status_o[15:8]);
  // exception sets EXL over both mtc0 and ERET
  always_comb begin
    status_n = wr_status ? data_i & STATUS_MASK : status_o;
    status_n[1] = exc_valid_i ? 1'b1 : eret_i ? 1'b0 : status_n[1];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
      count_o <= '0;
      compare_o <= '0;
      armed <= 1'b0;
      ti <= 1'b0;
      status_o <= 32'h1000_0000;
      epc_o <= '0;
      bd <= 1'b0;
      iv <= 1'b0;
      wp <= 1'b0;
      sw_ip <= '0;
      code <= '0;
      hw_ip <= '0;
    end else begin
      pre <= (wr_count || tick) ? 4'd0 : pre + 4'd1;
      count_o <= wr_count ? data_i : count_o + {31'b0, tick};
      compare_o <= wr_compare ? data_i : compare_o;
      armed <= armed | wr_compare;
      ti <= wr_compare ? 1'b0 : ti | (armed & tick & count_o == compare_o);
      status_o <= status_n;
      epc_o <= enter ? current_inst_addr_i - (is_in_delayslot_i ? 32'd4 : 32'd0) : wr_epc ? data_i : epc_o;
      bd <= enter ? is_in_delayslot_i : bd;
      code <= exc_valid_i ? exc_code_i : code;
      sw_ip <= wr_cause ? data_i[9:8] : sw_ip;
      iv <= wr_cause ? data_i[23] : iv;
      wp <= wr_cause ? data_i[22] : wp;
      hw_ip <= int_i;
    end
  end
`ifdef CP0_BADVADDR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) badvaddr_o <= '0;
    else if (exc_valid_i && (exc_code_i == 5'd4 || exc_code_i == 5'd5)) badvaddr_o <= badvaddr_i;
  end
`else
  logic unused_badvaddr;
  assign unused_badvaddr = ^badvaddr_i;
  assign badvaddr_o = '0;
`endif
  always_comb begin
    data_o = '0;
    if (rst)
      case (raddr_i)
        5'd8: data_o = badvaddr_o;
        5'd9: data_o = count_o;
        5'd11: data_o = compare_o;
        5'd12: data_o = status_o;
        5'd13: data_o = cause_o;
        5'd14: data_o = epc_o;
        5'd15: data_o = PRID_VALUE;
        5'd16: data_o = CONFIG_VALUE;
        default: data_o = '0;
      endcase
  end
endmodule
